// File: rtl/counter4_cout_pkg.sv
// counter4_cout_pkg: shared width, reset value and count type for the counter slice
package counter4_cout_pkg;
  localparam int COUNTER4_COUT_WIDTH = 4;
  typedef logic [COUNTER4_COUT_WIDTH-1:0] count_t;
  localparam count_t COUNTER4_COUT_INIT = 4'h0;
endpackage

// File: rtl/counter4_cout_incr.sv
// counter4_cout_incr: combinational ripple half-adder incrementer
//   count_i : value to increment
//   sum_o   : count_i + 1 modulo 2^WIDTH
//   cout_o  : carry out of the top bit, high only when count_i is all ones
module counter4_cout_incr #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] count_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);
  logic [WIDTH:0] c;
  assign c[0] = 1'b1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ha
    assign sum_o[i] = count_i[i] ^ c[i];
    assign c[i+1]   = count_i[i] & c[i];
  end
  assign cout_o = c[WIDTH];
endmodule

// File: rtl/counter4_cout.sv
// counter4_cout: free-running up-counter with carry-out for cascading / divide-by-2^WIDTH ticks
//   CLK   : clock, rising edge
//   RESET : synchronous active-high, loads INIT
//   CE    : count enable, only when COUNTER4_COUT_CE_EN is defined
//   O     : current count, straight from the register
//   COUT  : high while O is all ones (gated by CE when present)
module counter4_cout
  import counter4_cout_pkg::*;
#(
  parameter int               WIDTH = COUNTER4_COUT_WIDTH,
  parameter logic [WIDTH-1:0] INIT  = WIDTH'(COUNTER4_COUT_INIT)
) (
  input  logic             CLK,
  input  logic             RESET,
`ifdef COUNTER4_COUT_CE_EN
  input  logic             CE,
`endif
  output logic [WIDTH-1:0] O,
  output logic             COUT
);
  // Declaration initializer gives the power-up value without needing a reset.
  logic [WIDTH-1:0] count_q = INIT;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] sum;
  logic             carry;
  counter4_cout_incr #(.WIDTH(WIDTH)) u_incr (
    .count_i(count_q),
    .sum_o  (sum),
    .cout_o (carry)
  );
`ifdef COUNTER4_COUT_CE_EN
  assign count_d = CE ? sum : count_q;
  // Gating with CE lets a cascaded stage advance only when this one wraps.
  assign COUT    = carry & CE;
`else
  assign count_d = sum;
  assign COUT    = carry;
`endif
  always_ff @(posedge CLK) begin
    if (RESET) count_q <= INIT;
    else       count_q <= count_d;
  end
  assign O = count_q;
endmodule

// File: tb/tb_counter4_cout.sv
// tb_counter4_cout: directed table-driven bench for counter4_cout
module tb_counter4_cout;
  import counter4_cout_pkg::*;
  logic   CLK = 1'b0;
  logic   RESET = 1'b0;
`ifdef COUNTER4_COUT_CE_EN
  logic   CE = 1'b1;
`endif
  count_t O;
  logic   COUT;
  int     total = 0;
  int     bad = 0;

  typedef struct {
    logic   rst;
    logic   ce;
    count_t o;
    logic   c;
    string  name;
  } vec_t;
  vec_t tbl[$];

  counter4_cout dut (
    .CLK  (CLK),
    .RESET(RESET),
`ifdef COUNTER4_COUT_CE_EN
    .CE   (CE),
`endif
    .O    (O),
    .COUT (COUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input count_t exp_o, input logic exp_c);
    total++;
    if (O !== exp_o || COUT !== exp_c) begin
      bad++;
      $display("FAIL %s: got O=%h COUT=%b, want O=%h COUT=%b", name, O, COUT, exp_o, exp_c);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic add(input logic r, input logic ce, input count_t o, input logic c, input string n);
    tbl.push_back('{r, ce, o, c, n});
  endtask

  initial begin
    int highs;
    int guard;
    // free run continuing from 7, wrap, reset mid-count at 9
    add(0, 1, 4'h8, 0, "run8");  add(0, 1, 4'h9, 0, "run9");
    add(0, 1, 4'hA, 0, "runA");  add(0, 1, 4'hB, 0, "runB");
    add(0, 1, 4'hC, 0, "runC");  add(0, 1, 4'hD, 0, "runD");
    add(0, 1, 4'hE, 0, "runE");  add(0, 1, 4'hF, 1, "runF");
    add(0, 1, 4'h0, 0, "wrap0"); add(0, 1, 4'h1, 0, "wrap1");
    add(0, 1, 4'h2, 0, "wrap2"); add(0, 1, 4'h3, 0, "wrap3");
    add(0, 1, 4'h4, 0, "wrap4"); add(0, 1, 4'h5, 0, "cnt5");
    add(0, 1, 4'h6, 0, "cnt6");  add(0, 1, 4'h7, 0, "cnt7");
    add(0, 1, 4'h8, 0, "cnt8");  add(0, 1, 4'h9, 0, "cnt9");
    add(1, 1, 4'h0, 0, "rst_mid"); add(0, 1, 4'h1, 0, "after_rst");
    add(0, 1, 4'h2, 0, "after_rst2");

    #1 chk("powerup_edge1_pre", 4'h0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("powerup_edge%0d", k + 1), count_t'(k), 1'b0);
    end
    step();
    chk("powerup_edge7", 4'h7, 1'b0);

    foreach (tbl[i]) begin
      RESET = tbl[i].rst;
`ifdef COUNTER4_COUT_CE_EN
      CE = tbl[i].ce;
`endif
      step();
      chk(tbl[i].name, tbl[i].o, tbl[i].c);
    end
    RESET = 1'b0;

    // COUT duty: exactly two highs in 32 free-running cycles
    highs = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      if (COUT) highs++;
    end
    total++;
    if (highs != 2) begin
      bad++;
      $display("FAIL cout_duty: got %0d highs in 32 cycles, want 2", highs);
    end

    // reset held high from O = F
    guard = 0;
    while (O !== 4'hF && guard < 20) begin
      step();
      guard++;
    end
    chk("reach_F", 4'hF, 1'b1);
    RESET = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rst_hold%0d", k), 4'h0, 1'b0);
    end
    RESET = 1'b0;
    step();
    chk("rst_release", 4'h1, 1'b0);

`ifdef COUNTER4_COUT_CE_EN
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("ce_reach5", 4'h5, 1'b0);
    CE = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("ce_hold%0d", k), 4'h5, 1'b0);
    end
    CE = 1'b1;
    for (int k = 0; k < 10; k++) step();
    CE = 1'b0;
    #1 chk("ce0_at_F", 4'hF, 1'b0);
    CE = 1'b1;
    #1 chk("ce1_at_F", 4'hF, 1'b1);
    step();
    chk("ce_wrap", 4'h0, 1'b0);
    for (int k = 0; k < 3; k++) step();
    RESET = 1'b1;
    CE = 1'b0;
    step();
    chk("rst_over_ce", 4'h0, 1'b0);
    RESET = 1'b0;
    step();
    chk("ce0_after_rst", 4'h0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/counter4_cout.md
# counter4_cout

Free-running 4-bit binary up-counter with carry-out. `Counter4_COUT` increments its registered count on every rising clock edge and raises `COUT` while the count is at its maximum, so that counters can be cascaded into wider counters or used as divide-by-16 tick sources. It is a leaf block in the timing and sequencing logic, with no bus interface.

## Interface
Parameters:
- `WIDTH`, default 4: counter width in bits. All behaviour below is stated for 4; any `WIDTH` ≥ 1 must behave the same way at width `WIDTH`.
- `INIT`, default 0: value loaded by reset and held at power-up.

Ports:
- `CLK`, input, 1 bit: clock. All state changes on the rising edge. One clock; no other clock domains.
- `RESET`, input, 1 bit: reset, synchronous and active-high. When high at a rising edge of `CLK`, the count is loaded with `INIT`.
- `CE`, input, 1 bit: count enable. Present only when `COUNTER4_COUT_CE_EN` is defined; see Configuration.
- `O`, output, `WIDTH` bits: current count, driven directly from the count register.
- `COUT`, output, 1 bit: carry-out of the incrementer. Combinational from `O`.

## Operation
- State is a single `WIDTH`-bit count register, and `O` is that register.
- At each rising edge, in priority order:
  - if `RESET` = 1, count ← `INIT`;
  - otherwise, count ← (count + 1) mod 2^`WIDTH`.
- Wrap-around: 4'hF → 4'h0 with no stall and no saturation.
- `COUT` = carry out of the `WIDTH`-bit increment, so `COUT` = 1 exactly when `O` is all ones (4'hF); otherwise `COUT` = 0.
- Reset values:
  - `O` = `INIT` (4'h0).
  - `COUT` = 0, unless `INIT` is all ones.
- Power-up: the count register has an initial value of `INIT`, so a run with `RESET` never asserted counts 0, 1, 2, … from the first edge.
- Reset mid-count: reset takes effect at the next rising edge and overrides the increment. The count value before that edge is irrelevant.
- `RESET` held high keeps `O` at `INIT` indefinitely.

## Timing
- Increment latency is 1 cycle: `O` changes only just after a rising edge.
- A sample taken at a rising edge (before the nonblocking update) sees the pre-edge value. After the k-th edge following reset or power-up, `O` = k mod 16.
- `COUT` follows `O` combinationally within the same cycle. It is high for exactly one cycle in every 16 while counting freely, namely the cycle in which `O` = 4'hF.
- There are no multicycle or false paths. The critical path is the incrementer carry chain.

## Configuration
- Macro: `COUNTER4_COUT_CE_EN`.
- Defined:
  - The `CE` input exists.
  - The count increments only at edges where `CE` = 1 (and `RESET` = 0). With `CE` = 0 the count holds.
  - `RESET` has priority over `CE`.
  - `COUT` = (`O` all ones) AND `CE`, so that cascaded stages step together.
- Undefined:
  - No `CE` port exists.
  - The counter counts every cycle, and `COUT` is as given under Operation.

## Structure
- Shared package `counter4_cout_pkg` holds:
  - localparam `COUNTER4_COUT_WIDTH` = 4;
  - localparam `COUNTER4_COUT_INIT` = 4'h0;
  - typedef `count_t`, a logic vector of that width.
- One sub-module, `counter4_cout_incr`: a combinational ripple half-adder incrementer that produces sum and carry-out from the count. The top level contains only the register, the reset/enable mux, and the output assignments.

## Test plan
- Power-up with no reset: toggle `CLK` with a 10-unit period and sample at each rising edge. Edges 1–7 must read `O` = 0, 1, 2, 3, 4, 5, 6, with `COUT` = 0 throughout.
- Free run for 20 edges: after 15 edges `O` = 4'hF and `COUT` = 1; after edge 16 `O` = 4'h0 and `COUT` = 0. `COUT` must be high in exactly one of each 16 cycles.
- Reset mid-count: count to 4'h9, then hold `RESET` = 1 for one edge. Then `O` = 0, and the following edge gives `O` = 1.
- Reset held high while `O` = 4'hF: `O` goes to 0 at the next edge and stays 0 for 3 edges, and `COUT` = 0.
- With `COUNTER4_COUT_CE_EN` defined:
  - `CE` = 0 for 3 edges at `O` = 4'h5 → `O` stays 5.
  - At `O` = 4'hF with `CE` = 0 → `COUT` = 0. With `CE` = 1 → `COUT` = 1, and `O` wraps to 0.
  - `RESET` = 1 with `CE` = 0 → `O` = 0.
